// File: rtl/gpc_mem_pkg.sv
// Shared types and constants for the sys_mem arbiter slice.
package gpc_mem_pkg;

    localparam int   MEM_ADDR_W = 6;
    localparam int   MEM_DATA_W = 8;
    localparam logic MODE_RD    = 1'b0;
    localparam logic MODE_WR    = 1'b1;

    // Arbiter sequencing states
    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        ERASE,
        DONE
    } state_t;

    // Who owns the access currently in flight
    typedef enum logic [1:0] {
        OWN_A,
        OWN_B,
        OWN_ER
    } owner_t;

endpackage

// File: rtl/mem_rr_arb2.sv
// Two-way round-robin pick. Bit 0 is port A, bit 1 is port B.
// rr_ptr_i = 0 prefers A on a tie, 1 prefers B. A lone requester always wins.
module mem_rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       rr_ptr_i,
    output logic [1:0] grant_o
);

    // Purely combinational: the pointer register lives in the parent
    always_comb begin
        grant_o = 2'b00;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = rr_ptr_i ? 2'b10 : 2'b01;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/sys_mem_arbiter.sv
// Sole driver of sys_mem: arbitrates fetch (A), data (B) and erase requests and
// holds the memory pins stable for the read/write hold times the memory needs.
module sys_mem_arbiter
    import gpc_mem_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 8,
    parameter int RD_WAIT = 3,
    parameter int WR_WAIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_adrs,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_adrs,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    input  logic              erase_req,
    output logic              erase_ack,
    output logic [ADDR_W-1:0] mem_adrs,
    output logic              mem_mode,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_erase,
    input  logic [DATA_W-1:0] mem_out
);

    localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT - 1);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rr_q, rr_d;          // 0 = prefer A, 1 = prefer B
    logic [ADDR_W-1:0] mem_adrs_q, mem_adrs_d;
    logic              mem_mode_q, mem_mode_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              mem_erase_q, mem_erase_d;
    logic              a_ack_q, a_ack_d;
    logic              b_ack_q, b_ack_d;
    logic              er_ack_q, er_ack_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

    logic [1:0]        grant;
    logic              sel_b;
    logic              sel_we;

    mem_rr_arb2 u_rr (
        .req_i    ({b_req, a_req}),
        .rr_ptr_i (rr_q),
        .grant_o  (grant)
    );

    assign sel_b  = grant[1];
    assign sel_we = sel_b ? b_we : a_we;

    // Next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        rr_d        = rr_q;
        mem_adrs_d  = mem_adrs_q;
        mem_mode_d  = mem_mode_q;
        mem_data_d  = mem_data_q;
        mem_erase_d = mem_erase_q;
        a_ack_d     = 1'b0;
        b_ack_d     = 1'b0;
        er_ack_d    = 1'b0;
        a_rdata_d   = a_rdata_q;
        b_rdata_d   = b_rdata_q;

        case (state_q)
            IDLE: begin
                if (erase_req) begin
                    // Erase outranks both ports and leaves rr pointer alone
                    owner_d     = OWN_ER;
                    mem_erase_d = 1'b1;
                    state_d     = ERASE;
                end else if (grant != 2'b00) begin
                    owner_d    = sel_b ? OWN_B : OWN_A;
                    rr_d       = ~sel_b;       // next tie goes to the other port
                    mem_adrs_d = sel_b ? b_adrs : a_adrs;
                    if (sel_we) begin
                        mem_data_d = sel_b ? b_wdata : a_wdata;
                        mem_mode_d = MODE_WR;
                        cnt_d      = WR_LOAD;
                        state_d    = WRITE;
                    end else begin
                        mem_mode_d = MODE_RD;
                        cnt_d      = RD_LOAD;
                        state_d    = READ;
                    end
                end
            end
            READ: begin
                mem_mode_d = MODE_RD;
                if (cnt_q == '0) begin
                    if (owner_q == OWN_B) begin
                        b_rdata_d = mem_out;
                        b_ack_d   = 1'b1;
                    end else begin
                        a_rdata_d = mem_out;
                        a_ack_d   = 1'b1;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WRITE: begin
                if (cnt_q == '0) begin
                    mem_mode_d = MODE_RD;
                    a_ack_d    = (owner_q == OWN_A);
                    b_ack_d    = (owner_q == OWN_B);
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ERASE: begin
                mem_erase_d = 1'b0;
                er_ack_d    = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                // Ack is visible this cycle; requester drops req now
                state_d = IDLE;
            end
            default: begin
                state_d    = IDLE;
                mem_mode_d = MODE_RD;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_A;
            cnt_q       <= '0;
            rr_q        <= 1'b0;
            mem_adrs_q  <= '0;
            mem_mode_q  <= MODE_RD;
            mem_data_q  <= '0;
            mem_erase_q <= 1'b0;
            a_ack_q     <= 1'b0;
            b_ack_q     <= 1'b0;
            er_ack_q    <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            rr_q        <= rr_d;
            mem_adrs_q  <= mem_adrs_d;
            mem_mode_q  <= mem_mode_d;
            mem_data_q  <= mem_data_d;
            mem_erase_q <= mem_erase_d;
            a_ack_q     <= a_ack_d;
            b_ack_q     <= b_ack_d;
            er_ack_q    <= er_ack_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
        end
    end

    assign a_ack     = a_ack_q;
    assign b_ack     = b_ack_q;
    assign erase_ack = er_ack_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign mem_adrs  = mem_adrs_q;
    assign mem_mode  = mem_mode_q;
    assign mem_data  = mem_data_q;
    assign mem_erase = mem_erase_q;

endmodule

// File: tb/tb_sys_mem_arbiter.sv
// Randomized scoreboard bench for sys_mem_arbiter with a behavioural sys_mem.
module tb_sys_mem_arbiter;

    localparam int AW = 6;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_req, a_we, b_req, b_we, erase_req;
    logic [AW-1:0] a_adrs, b_adrs;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_ack, b_ack, erase_ack;
    logic [DW-1:0] a_rdata, b_rdata;
    logic [AW-1:0] mem_adrs;
    logic          mem_mode, mem_erase;
    logic [DW-1:0] mem_data, mem_out;

    always #5 clk = ~clk;

    sys_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_adrs(a_adrs), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_adrs(b_adrs), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .erase_req(erase_req), .erase_ack(erase_ack),
        .mem_adrs(mem_adrs), .mem_mode(mem_mode), .mem_data(mem_data),
        .mem_erase(mem_erase), .mem_out(mem_out)
    );

    // Behavioural sys_mem: 64x8, write while mode=1, erase clears all, registered read
    logic [DW-1:0] smem [64];
    always @(posedge clk) begin
        if (mem_erase) begin
            for (int i = 0; i < 64; i++) smem[i] <= '0;
        end else if (mem_mode) begin
            smem[mem_adrs] <= mem_data;
        end
        mem_out <= smem[mem_adrs];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard entry: port 0=A 1=B 2=erase
    typedef struct {
        int            port;
        bit            rd;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t          sbq[$];
    logic [DW-1:0] ref_mem [64];
    bit            rr_m;
    int            vectors = 0;
    int            miscompares = 0;

    task automatic chk(input string nm, input longint act, input longint req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever any ack appears
    initial begin : monitor
        logic [DW-1:0] last_a, last_b;
        exp_t          ev;
        int            run;
        last_a = '0; last_b = '0; run = 0;
        forever begin
            @(negedge clk);
            if (mem_mode) begin
                run++;
                chk("mode_run_len", longint'(run <= 3 && !mem_erase), 1);
            end else begin
                run = 0;
            end
            if (reset) begin
                last_a = '0;
                last_b = '0;
            end else if (a_ack || b_ack || erase_ack) begin
                if (sbq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_ack: a=%0b b=%0b e=%0b, expected none", a_ack, b_ack, erase_ack);
                end else begin
                    ev = sbq.pop_front();
                    chk("ack_port", {a_ack, b_ack, erase_ack},
                        (ev.port == 0) ? 3'b100 : (ev.port == 1) ? 3'b010 : 3'b001);
                    chk("ack_cycle", ev.cyc == cyc ? 0 : cyc, 0);
                    chk("mode_at_ack", mem_mode, 0);
                    if (ev.rd && ev.port == 0) last_a = ev.data;
                    if (ev.rd && ev.port == 1) last_b = ev.data;
                    chk("a_rdata", a_rdata, last_a);
                    chk("b_rdata", b_rdata, last_b);
                end
            end
        end
    end

    // Apply one group of requests in IDLE, predict the service order, then act as requesters
    task automatic run_group(input int na, input bit wa, input int ada, input int da,
                             input int nb, input bit wb, input int adb, input int db,
                             input bit re);
        int   t, pa, ad;
        int   n[2];
        int   rem[2];
        bit   we;
        exp_t ev;
        @(negedge clk);
        a_req = (na > 0); a_we = wa; a_adrs = AW'(ada); a_wdata = DW'(da);
        b_req = (nb > 0); b_we = wb; b_adrs = AW'(adb); b_wdata = DW'(db);
        erase_req = re;
        t = cyc; n[0] = na; n[1] = nb;
        if (re) begin
            for (int i = 0; i < 64; i++) ref_mem[i] = '0;
            ev.port = 2; ev.rd = 0; ev.data = '0; ev.cyc = t + 2;
            sbq.push_back(ev);
            t = t + 3;
        end
        while (n[0] > 0 || n[1] > 0) begin
            if (n[0] > 0 && n[1] > 0) pa = rr_m ? 1 : 0;
            else pa = (n[0] > 0) ? 0 : 1;
            rr_m = (pa == 0);
            n[pa]--;
            we = pa ? wb : wa;
            ad = pa ? adb : ada;
            ev.port = pa; ev.rd = !we; ev.data = ref_mem[ad]; ev.cyc = t + 4;
            sbq.push_back(ev);
            if (we) ref_mem[ad] = DW'(pa ? db : da);
            t = t + 5;
        end
        rem[0] = na; rem[1] = nb;
        for (int k = 0; k < 300 && sbq.size() > 0; k++) begin
            @(negedge clk);
            if (erase_ack) erase_req = 1'b0;
            if (a_ack && rem[0] > 0) begin rem[0]--; if (rem[0] == 0) a_req = 1'b0; end
            if (b_ack && rem[1] > 0) begin rem[1]--; if (rem[1] == 0) b_req = 1'b0; end
        end
        if (sbq.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL ack_timeout: %0d acks outstanding, expected 0", sbq.size());
            sbq.delete();
        end
        a_req = 0; b_req = 0; erase_req = 0;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_mem_adrs"}, mem_adrs, 0);
        chk({tag, "_mem_mode"}, mem_mode, 0);
        chk({tag, "_mem_data"}, mem_data, 0);
        chk({tag, "_mem_erase"}, mem_erase, 0);
        chk({tag, "_acks"}, {a_ack, b_ack, erase_ack}, 0);
        chk({tag, "_a_rdata"}, a_rdata, 0);
        chk({tag, "_b_rdata"}, b_rdata, 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        reset = 0;
        rr_m = 0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int na, nb;
        reset = 1;
        a_req = 0; a_we = 0; a_adrs = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_adrs = '0; b_wdata = '0;
        erase_req = 0;
        rr_m = 0;
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("init");
        reset = 0;

        // Known-clean memory
        run_group(0, 0, 0, 0, 0, 0, 0, 0, 1);
        // Neighbours of adrs 9, then A write/read 9, then neighbours unchanged
        run_group(0, 0, 0, 0, 1, 1, 8, 8'h11, 0);
        run_group(0, 0, 0, 0, 1, 1, 10, 8'h22, 0);
        run_group(0, 0, 0, 0, 1, 1, 11, 8'h33, 0);
        run_group(1, 1, 9, 8'h5A, 0, 0, 0, 0, 0);
        run_group(1, 0, 9, 0, 0, 0, 0, 0, 0);
        run_group(1, 0, 8, 0, 1, 0, 10, 0, 0);
        run_group(0, 0, 0, 0, 1, 0, 11, 0, 0);

        // Tie from reset: A,B,A,B
        pulse_reset();
        run_group(2, 0, 9, 0, 2, 0, 10, 0, 0);

        // Erase beats a pending A read
        run_group(1, 0, 9, 0, 0, 0, 0, 0, 1);

        // Wrap edge at 63, then adrs 0 untouched
        run_group(1, 1, 0, 8'h77, 0, 0, 0, 0, 0);
        run_group(0, 0, 0, 0, 1, 1, 63, 8'hFF, 0);
        run_group(0, 0, 0, 0, 1, 0, 63, 0, 0);
        run_group(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // A held through its ack -> second access
        run_group(2, 0, 63, 0, 0, 0, 0, 0, 0);
        run_group(2, 1, 5, 8'h9C, 1, 0, 5, 0, 0);

        // Reset two cycles in the middle of a write: no ack, outputs cleared
        @(negedge clk);
        a_req = 1; a_we = 1; a_adrs = 6'd20; a_wdata = 8'hC3;
        @(negedge clk);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("midwr");
        a_req = 0;
        reset = 0;
        rr_m = 0;
        run_group(1, 1, 20, 8'hC3, 0, 0, 0, 0, 0);
        run_group(1, 0, 20, 0, 1, 0, 21, 0, 0);

        // Randomized groups
        for (int g = 0; g < 150; g++) begin
            na = $urandom_range(0, 2);
            nb = $urandom_range(0, 2);
            if (na == 0 && nb == 0) na = 1;
            run_group(na, 1'($urandom_range(0, 1)), $urandom_range(0, 63), $urandom_range(0, 255),
                      nb, 1'($urandom_range(0, 1)), $urandom_range(0, 63), $urandom_range(0, 255),
                      $urandom_range(0, 11) == 0);
        end

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
